// File: rtl/bram_stream_out.sv
// Streams a WIDTH x HEIGHT image out of a 2-cycle-latency BRAM as a valid/ready pixel stream.
// Optional STREAM_COORD_EN attaches the column/row of each pixel (x_out/y_out).
module bram_stream_out #(
  parameter int BIT_DEPTH  = 8,
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(WIDTH * HEIGHT),
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  output logic [AW-1:0]        ext_read_addr,
  output logic                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_in,
  output logic [BIT_DEPTH-1:0] pixel_out,
  output logic                 pixel_valid_out,
  input  logic                 pixel_ready_in,
  output logic                 last_out,
  output logic [XW-1:0]        x_out,
  output logic [YW-1:0]        y_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [1:0]           state_out
);

  // Stream handshake: a pixel transfers on any rising edge where pixel_valid_out
  // and pixel_ready_in are both high; valid never drops and data never changes
  // while waiting for ready.

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1) + 1;
`ifdef STREAM_COORD_EN
  localparam int EW = BIT_DEPTH + 1 + XW + YW;
`else
  localparam int EW = BIT_DEPTH + 1;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_cnt;
  logic            issue, issue_last, credit;
  logic            push, pop, fifo_valid, head_last, done_r;
  logic [CW-1:0]   fifo_count, in_flight;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   head, push_entry;
  logic [1:0]      pipe_v, pipe_last;

  assign issue_last = (addr_cnt == AW'(NPIX - 1));
  // Credits use registered occupancy only, so a pop this cycle frees nothing until next cycle.
  assign credit     = (fifo_count + in_flight) < CW'(FIFO_DEPTH);
  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && pixel_ready_in;
  assign push       = pipe_v[1];
  assign head       = mem[rd_ptr];
  assign head_last  = head[BIT_DEPTH];

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start_in) state_nxt = RUN;
      RUN: begin
        if (credit) begin
          issue = 1'b1;
          if (issue_last) state_nxt = DRAIN;
        end
      end
      DRAIN: if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      pipe_v    <= '0;
      pipe_last <= '0;
      in_flight <= '0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pipe_v    <= {pipe_v[0], issue};
      pipe_last <= {pipe_last[0], issue && issue_last};
      done_r    <= (state == DRAIN) && pop && head_last;
      if (state == IDLE && start_in) addr_cnt <= '0;
      else if (issue && !issue_last) addr_cnt <= addr_cnt + AW'(1);
      case ({issue, push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef STREAM_COORD_EN
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [XW-1:0] pipe_x [2];
  logic [YW-1:0] pipe_y [2];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      pipe_x[0] <= '0;
      pipe_x[1] <= '0;
      pipe_y[0] <= '0;
      pipe_y[1] <= '0;
    end else begin
      pipe_x[0] <= x_cnt;
      pipe_x[1] <= pipe_x[0];
      pipe_y[0] <= y_cnt;
      pipe_y[1] <= pipe_y[0];
      if (state == IDLE && start_in) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        if (x_cnt == XW'(WIDTH - 1)) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
    end
  end

  assign push_entry = {pipe_y[1], pipe_x[1], pipe_last[1], ext_pixel_in};
  assign x_out      = fifo_valid ? head[BIT_DEPTH+1 +: XW] : '0;
  assign y_out      = fifo_valid ? head[BIT_DEPTH+1+XW +: YW] : '0;
`else
  assign push_entry = {pipe_last[1], ext_pixel_in};
  assign x_out      = '0;
  assign y_out      = '0;
`endif

  assign ext_read_addr       = addr_cnt;
  assign ext_read_addr_valid = issue;
  assign pixel_valid_out     = fifo_valid;
  assign pixel_out           = fifo_valid ? head[BIT_DEPTH-1:0] : '0;
  assign last_out            = fifo_valid && head_last;
  assign busy_out            = (state != IDLE);
  assign done_out            = done_r;
  assign state_out           = state;

endmodule

// File: tb/tb_bram_stream_out.sv
// Bench for bram_stream_out on a 4x2 image (pixel = address*3) behind a 2-cycle BRAM model.
// Define STREAM_COORD_EN to exercise the coordinate outputs.
module tb_bram_stream_out;
  localparam int BD = 8, W = 4, H = 2, FD = 4, NP = W * H;

  logic          clk_in = 1'b0;
  logic          rst_n_in, start_in, pixel_ready_in;
  logic [2:0]    ext_read_addr;
  logic          ext_read_addr_valid;
  logic [BD-1:0] ext_pixel_in = '0;
  logic [BD-1:0] pixel_out;
  logic          pixel_valid_out, last_out, busy_out, done_out;
  logic [1:0]    x_out;
  logic [0:0]    y_out;
  logic [1:0]    state_out;

  int total = 0, bad = 0;
  logic [BD-1:0] bram [NP];
  logic [BD-1:0] bram_d1 = '0;
  logic [BD-1:0] exp_q[$];

  bram_stream_out #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(FD)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .ext_read_addr(ext_read_addr), .ext_read_addr_valid(ext_read_addr_valid),
    .ext_pixel_in(ext_pixel_in), .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out),
    .pixel_ready_in(pixel_ready_in), .last_out(last_out), .x_out(x_out), .y_out(y_out),
    .busy_out(busy_out), .done_out(done_out), .state_out(state_out)
  );

  // clock / reset block and BRAM model (address sampled, data two edges later)
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    bram_d1      <= bram[ext_read_addr];
    ext_pixel_in <= bram_d1;
  end

  typedef struct {
    logic          ready;
    logic          av;
    logic [2:0]    addr;
    logic          pv;
    logic [BD-1:0] pix;
    logic          last;
    logic          busy;
    logic          done;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pv"}, pixel_valid_out, 0);
    check({tag, "_pix"}, pixel_out, 0);
    check({tag, "_last"}, last_out, 0);
    check({tag, "_av"}, ext_read_addr_valid, 0);
    check({tag, "_addr"}, ext_read_addr, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, done_out, 0);
    check({tag, "_x"}, x_out, 0);
    check({tag, "_y"}, y_out, 0);
  endtask

  // mode 0: ready high, 1: ready 1010..., 2: ready low 20 cycles, 3: ready high + second start at pixel 3
  task automatic run_image(input int mode);
    int reads = 0, pops = 0, dones = 0, after_done = -1;
    logic restarted = 1'b0;
    logic [BD-1:0] e;
    exp_q.delete();
    for (int a = 0; a < NP; a++) exp_q.push_back(BD'(a * 3));
    @(negedge clk_in);
    start_in = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      if (mode == 3 && pops == 3 && !restarted) begin
        start_in  = 1'b1;
        restarted = 1'b1;
      end
      case (mode)
        1:       pixel_ready_in = (cyc % 2 == 0);
        2:       pixel_ready_in = (cyc >= 20);
        default: pixel_ready_in = 1'b1;
      endcase
      check("fifo_bound", 32'(dut.fifo_count <= FD), 1);
      if (ext_read_addr_valid) begin
        check("read_addr", ext_read_addr, reads);
        reads++;
      end
      if (mode == 2 && cyc == 19) begin
        check("stall_reads", reads, FD);
        check("stall_av", ext_read_addr_valid, 0);
      end
      if (done_out) dones++;
      if (pixel_valid_out && pixel_ready_in) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", pixel_out, 0);
          bad++;
        end else begin
          e = exp_q.pop_front();
          check("pixel", pixel_out, e);
          check("last", last_out, exp_q.size() == 0);
`ifdef STREAM_COORD_EN
          check("x", x_out, pops % W);
          check("y", y_out, pops / W);
`else
          check("x", x_out, 0);
          check("y", y_out, 0);
`endif
        end
        pops++;
      end else if (pixel_valid_out) begin
        check("last_hold", last_out, exp_q.size() == 1);
      end
      if (dones > 0 && after_done < 0) after_done = 0;
      if (after_done >= 0) begin
        after_done++;
        if (after_done > 4) break;
      end
    end
    start_in = 1'b0;
    check("completed", 32'(after_done >= 0), 1);
    check("all_popped", exp_q.size(), 0);
    check("reads_total", reads, NP);
    check("done_count", dones, 1);
    check("busy_after", busy_out, 0);
  endtask

  initial begin
    for (int a = 0; a < NP; a++) bram[a] = BD'(a * 3);
    for (int j = 0; j < 13; j++) begin
      vecs[j].ready = 1'b1;
      vecs[j].av    = (j < 8);
      vecs[j].addr  = 3'(j);
      vecs[j].pv    = (j >= 3 && j <= 10);
      vecs[j].pix   = vecs[j].pv ? BD'((j - 3) * 3) : '0;
      vecs[j].last  = (j == 10);
      vecs[j].busy  = (j <= 10);
      vecs[j].done  = (j == 11);
    end

    rst_n_in = 1'b0;
    start_in = 1'b0;
    pixel_ready_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_idle_outputs("reset");
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // cycle-exact run, ready high throughout
    pixel_ready_in = 1'b1;
    start_in = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      pixel_ready_in = vecs[j].ready;
      check($sformatf("t1_av[%0d]", j), ext_read_addr_valid, vecs[j].av);
      if (vecs[j].av) check($sformatf("t1_addr[%0d]", j), ext_read_addr, vecs[j].addr);
      check($sformatf("t1_pv[%0d]", j), pixel_valid_out, vecs[j].pv);
      check($sformatf("t1_pix[%0d]", j), pixel_out, vecs[j].pix);
      check($sformatf("t1_last[%0d]", j), last_out, vecs[j].last);
      check($sformatf("t1_busy[%0d]", j), busy_out, vecs[j].busy);
      check($sformatf("t1_done[%0d]", j), done_out, vecs[j].done);
    end

    run_image(1);
    run_image(2);
    run_image(3);

    // asynchronous reset between edges in the middle of a stream
    pixel_ready_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check("pre_reset_busy", busy_out, 1);
    @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("post_rst_pv", pixel_valid_out, 0);
    check("post_rst_busy", busy_out, 0);
    run_image(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
